// File: rtl/ddr_tx_sequencer.sv
// Link start-up sequencer in front of a 2-bit-per-clock DDR serializer: preamble, idle, sync, LSB-first bursts.
// Serializer outputs are registered (one clock after the state); ready_o is combinational and only high in IDLE or on a last beat.
module ddr_tx_sequencer #(
  parameter int WIDTH        = 16,
  parameter int PREAMBLE_LEN = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             bypass_req_i,
  input  logic             bypass_bit_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [1:0]       ser_data_o,
  output logic             ser_bypass_o,
  output logic             busy_o,
  output logic [15:0]      words_sent_o
);

  localparam int BEATS   = WIDTH / 2;
  localparam int CNT_MAX = (BEATS > PREAMBLE_LEN) ? BEATS : PREAMBLE_LEN;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_BYPASS,
    S_TRAIN,
    S_IDLE,
    S_SYNC,
    S_STREAM
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    beat_q, beat_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [1:0]       ser_data_q, ser_data_d;
  logic             ser_bypass_q, ser_bypass_d;
  logic [15:0]      words_sent_q, words_sent_d;
  logic             last_beat;
  logic             train_done;
  logic             accept;

  assign last_beat  = (state_q == S_STREAM) && (beat_q == CW'(BEATS - 1));
  assign train_done = (beat_q == CW'(PREAMBLE_LEN - 1));
  // Requests are only honoured at word boundaries, so ready is gated the same way.
  assign ready_o    = enable_i && !bypass_req_i && ((state_q == S_IDLE) || last_beat);
  assign accept     = valid_i && ready_o;

  always_comb begin
    state_d      = state_q;
    beat_d       = '0;
    shreg_d      = shreg_q;
    words_sent_d = words_sent_q;
    ser_data_d   = 2'b00;
    ser_bypass_d = 1'b0;
    case (state_q)
      S_OFF: begin
        if (bypass_req_i)  state_d = S_BYPASS;
        else if (enable_i) state_d = S_TRAIN;
      end
      S_BYPASS: begin
        ser_bypass_d = 1'b1;
        ser_data_d   = {1'b0, bypass_bit_i};
        if (!bypass_req_i) state_d = enable_i ? S_TRAIN : S_OFF;
      end
      S_TRAIN: begin
        ser_data_d = 2'b01;
        if (bypass_req_i)    state_d = S_BYPASS;
        else if (!enable_i)  state_d = S_OFF;
        else if (train_done) state_d = S_IDLE;
        else                 beat_d  = beat_q + 1'b1;
      end
      S_IDLE: begin
        if (accept) begin
          shreg_d = word_i;
          state_d = S_SYNC;
        end else if (bypass_req_i) begin
          state_d = S_BYPASS;
        end else if (!enable_i) begin
          state_d = S_OFF;
        end
      end
      S_SYNC: begin
        ser_data_d = 2'b11;
        state_d    = S_STREAM;
      end
      S_STREAM: begin
        for (int i = 0; i < BEATS; i++) begin
          if (beat_q == CW'(i)) ser_data_d = shreg_q[2*i +: 2];
        end
        if (last_beat) begin
          words_sent_d = words_sent_q + 16'd1;
          // A handshake here chains the next word with no sync and no gap.
          if (accept)             shreg_d = word_i;
          else if (bypass_req_i)  state_d = S_BYPASS;
          else if (!enable_i)     state_d = S_OFF;
          else                    state_d = S_IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_OFF;
      beat_q       <= '0;
      shreg_q      <= '0;
      ser_data_q   <= 2'b00;
      ser_bypass_q <= 1'b0;
      words_sent_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      shreg_q      <= shreg_d;
      ser_data_q   <= ser_data_d;
      ser_bypass_q <= ser_bypass_d;
      words_sent_q <= words_sent_d;
    end
  end

  assign ser_data_o   = ser_data_q;
  assign ser_bypass_o = ser_bypass_q;
  assign busy_o       = (state_q == S_SYNC) || (state_q == S_STREAM);
  assign words_sent_o = words_sent_q;

endmodule
